// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared states and defaults for the frequency meter.
package freq_meter_pkg;
    localparam int DEF_CLK_HZ = 100_000_000;
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, GATE = 2'd2, LATCH = 2'd3} state_t;
endpackage

// File: rtl/freq_meter_edge_sync.sv
// edge_sync: multi-flop synchronizer with a history flop for rising-edge detection.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_async,
    output logic q_sync,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d_async};
            hist <= sync[SYNC_STAGES-1];
        end
    end
    assign q_sync = sync[SYNC_STAGES-1];
    assign rise   = q_sync & ~hist;
endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts sig_in rising edges over a GATE_CYCLES window and publishes the count.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int GATE_CYCLES = CLK_HZ,
    parameter int CNT_W       = 28,
    parameter int GATE_W      = 28,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy
);
    state_t              state, nxt;
    logic [GATE_W-1:0]   gate_cnt;
    logic [CNT_W-1:0]    edge_cnt;
    logic                sat;
    logic                sig_sync, sig_rise, edge_s, last;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .reset(reset),
        .d_async(sig_in),
        .q_sync(sig_sync),
        .rise(sig_rise)
    );

    assign edge_s = sig_rise & sig_sync;
    assign last   = gate_cnt == GATE_W'(GATE_CYCLES - 1);
    assign busy   = state != IDLE;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  nxt = enable ? ARM : IDLE;
            ARM:   nxt = enable ? GATE : IDLE;
            GATE:  nxt = !enable ? IDLE : last ? LATCH : GATE;
            LATCH: nxt = enable ? ARM : IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            freq_out   <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= nxt;
            freq_valid <= state == LATCH;
            if (state == ARM) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end else if (state == GATE) begin
                gate_cnt <= gate_cnt + 1'b1;
                // edge_cnt sticks at all-ones; further edges only mark saturation
                if (edge_s) begin
                    if (&edge_cnt) sat <= 1'b1;
                    else edge_cnt <= edge_cnt + 1'b1;
                end
            end
            if (state == LATCH) begin
                freq_out <= edge_cnt;
                overflow <= sat;
            end
        end
    end
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: scoreboard bench; u_a uses a 28-bit counter, u_b a 4-bit counter.
module tb_freq_meter;
    typedef struct {int f; int o;} exp_t;

    logic        clk, reset;
    logic        sig_a, en_a, sig_b, en_b;
    logic [27:0] fo_a;
    logic [3:0]  fo_b;
    logic        fv_a, ov_a, bs_a, fv_b, ov_b, bs_b;
    int          per_a, per_b, hold_a;
    int          total, bad, cyc;
    int          ref_a, ref_b;
    logic        pv_a, pv_b, pb_a, pb_b;
    exp_t        qa[$], qb[$];

    freq_meter #(.GATE_CYCLES(100), .CNT_W(28), .GATE_W(28)) u_a (
        .clk(clk), .reset(reset), .sig_in(sig_a), .enable(en_a),
        .freq_out(fo_a), .freq_valid(fv_a), .overflow(ov_a), .busy(bs_a)
    );
    freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .GATE_W(28)) u_b (
        .clk(clk), .reset(reset), .sig_in(sig_b), .enable(en_b),
        .freq_out(fo_b), .freq_valid(fv_b), .overflow(ov_b), .busy(bs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_pending", qa.size() + qb.size(), 0);
    endtask

    initial begin
        int ph = 0;
        sig_a = 1'b0;
        forever begin
            @(negedge clk);
            if (per_a == 0) sig_a = hold_a[0];
            else begin
                ph = (ph + 1) % per_a;
                sig_a = ph < per_a / 2;
            end
        end
    end

    initial begin
        int ph = 0;
        sig_b = 1'b0;
        forever begin
            @(negedge clk);
            if (per_b == 0) sig_b = 1'b0;
            else begin
                ph = (ph + 1) % per_b;
                sig_b = ph < per_b / 2;
            end
        end
    end

    // each freq_valid is 102 cycles after the previous one or after ARM entry
    always @(negedge clk) begin
        exp_t e;
        if (bs_a && !pb_a) ref_a = cyc;
        pb_a = bs_a;
        if (fv_a) begin
            chk("a_valid_back_to_back", int'(pv_a), 0);
            if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_freq", int'(fo_a), e.f);
                chk("a_ovf", int'(ov_a), e.o);
                chk("a_gap", cyc - ref_a, 102);
            end
            ref_a = cyc;
        end
        pv_a = fv_a;
    end

    always @(negedge clk) begin
        exp_t e;
        if (bs_b && !pb_b) ref_b = cyc;
        pb_b = bs_b;
        if (fv_b) begin
            chk("b_valid_back_to_back", int'(pv_b), 0);
            if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_freq", int'(fo_b), e.f);
                chk("b_ovf", int'(ov_b), e.o);
                chk("b_gap", cyc - ref_b, 102);
            end
            ref_b = cyc;
        end
        pv_b = fv_b;
    end

    initial begin
        total = 0; bad = 0; cyc = 0;
        ref_a = 0; ref_b = 0;
        pv_a = 0; pv_b = 0; pb_a = 0; pb_b = 0;
        reset = 1'b1; en_a = 1'b0; en_b = 1'b0;
        per_a = 10; per_b = 4; hold_a = 0;
        repeat (3) tick();
        chk("rst_fo_a", int'(fo_a), 0);
        chk("rst_fv_a", int'(fv_a), 0);
        chk("rst_ov_a", int'(ov_a), 0);
        chk("rst_bs_a", int'(bs_a), 0);
        chk("rst_fo_b", int'(fo_b), 0);
        chk("rst_bs_b", int'(bs_b), 0);
        reset = 1'b0;
        repeat (5) tick();
        chk("idle_bs_a", int'(bs_a), 0);
        chk("idle_bs_b", int'(bs_b), 0);

        repeat (3) qa.push_back('{10, 0});
        repeat (3) qb.push_back('{15, 1});
        en_a = 1'b1; en_b = 1'b1;
        drain(400);
        en_a = 1'b0; en_b = 1'b0;
        tick();
        chk("stop_bs_a", int'(bs_a), 0);
        chk("stop_bs_b", int'(bs_b), 0);

        per_b = 20; per_a = 0; hold_a = 0;
        repeat (10) tick();
        repeat (2) qa.push_back('{0, 0});
        repeat (2) qb.push_back('{5, 0});
        en_a = 1'b1; en_b = 1'b1;
        drain(300);
        en_a = 1'b0; en_b = 1'b0;

        hold_a = 1;
        repeat (10) tick();
        repeat (2) qa.push_back('{0, 0});
        en_a = 1'b1;
        drain(300);
        en_a = 1'b0;

        per_a = 10;
        repeat (10) tick();
        qa.push_back('{10, 0});
        en_a = 1'b1;
        drain(200);
        repeat (51) tick();
        en_a = 1'b0;
        tick();
        chk("abort_bs_a", int'(bs_a), 0);
        chk("abort_fo_a", int'(fo_a), 10);
        chk("abort_ov_a", int'(ov_a), 0);
        repeat (110) tick();
        chk("abort_hold_fo_a", int'(fo_a), 10);
        repeat (2) qa.push_back('{10, 0});
        en_a = 1'b1;
        drain(300);

        repeat (40) tick();
        chk("mid_gate_bs_a", int'(bs_a), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_fo_a", int'(fo_a), 0);
        chk("async_rst_bs_a", int'(bs_a), 0);
        chk("async_rst_fv_a", int'(fv_a), 0);
        repeat (2) tick();
        reset = 1'b0;
        qa.push_back('{10, 0});
        drain(200);
        en_a = 1'b0;
        repeat (3) tick();

        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
